// File: rtl/banked_lsu.sv
// Byte-banked load/store unit: valid/ready request and response channels, synchronous-read
// byte banks, misaligned/illegal/access-fault detection and a registered response.
module banked_lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DEPTH          = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter bit          ALLOW_MISALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            busy
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned RW  = $clog2(DEPTH);
    localparam logic [32:0] CAP = 33'(DEPTH * NB);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [OFS-1:0]  b0_q, b0_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_err_q, rsp_err_d;

    // Request decode
    logic [32:0]    diff;
    logic [31:0]    off;
    logic [31:0]    row;
    logic [OFS-1:0] b0;
    logic [3:0]     size;
    logic [32:0]    last;
    logic           illegal, misal, fault;
    logic [1:0]     err;
    logic           accept;

    always_comb begin
        diff    = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        off     = diff[31:0];
        row     = off >> OFS;
        b0      = off[OFS-1:0];
        size    = 4'd1 << req_funct3[1:0];
        last    = {1'b0, off} + {29'd0, size} - 33'd1;
        illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        if (XLEN == 32) begin
            illegal = illegal || (req_funct3[1:0] == 2'b11) || (!req_we && req_funct3 == 3'b110);
        end
        misal  = (off[3:0] & (size - 4'd1)) != 4'd0;
        // diff[32] is the borrow: address below the window
        fault  = diff[32] || (last >= CAP);
        if (illegal)                      err = 2'b11;
        else if (misal && !ALLOW_MISALIGN) err = 2'b01;
        else if (fault)                   err = 2'b10;
        else                              err = 2'b00;
        accept = req_valid && (state_q == StIdle);
    end

    // Per-bank addressing: bank b carries access byte k = (b - b0) mod NB
    logic [NB-1:0]   bank_we, bank_re;
    logic [RW-1:0]   bank_row   [NB];
    logic [7:0]      bank_wbyte [NB];
    logic [7:0]      bank_rd    [NB];
    logic [OFS-1:0]  k;

    always_comb begin
        k = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            k             = OFS'(b) - b0;
            bank_row[b]   = RW'((OFS'(b) < b0) ? row + 32'd1 : row);
            bank_wbyte[b] = req_wdata[{k, 3'b000} +: 8];
            bank_we[b]    = accept && req_we && (err == 2'b00) && (4'(k) < size);
            bank_re[b]    = accept && !req_we && (err == 2'b00) && (4'(k) < size);
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (bank_we[b]) mem[bank_row[b]] <= bank_wbyte[b];
            if (bank_re[b]) rd_q <= mem[bank_row[b]];
        end

        assign bank_rd[b] = rd_q;
    end

    // Rotate bank outputs back into access order, then extend
    logic [XLEN-1:0] rot, ext;
    logic [OFS-1:0]  idx;
    int unsigned     sb;
    logic            sign;

    always_comb begin
        rot = '0;
        idx = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            idx            = OFS'(i) + b0_q;
            rot[8*i +: 8]  = bank_rd[idx];
        end
        sb = 32'd8 << funct3_q[1:0];
        if (sb > XLEN) sb = XLEN;
        sign = rot[sb-1] & ~funct3_q[2];
        ext  = '0;
        for (int unsigned j = 0; j < XLEN; j++) begin
            ext[j] = (j < sb) ? rot[j] : sign;
        end
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        b0_d        = b0_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    funct3_d    = req_funct3;
                    b0_d        = b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = err;
                    state_d     = (err == 2'b00 && !req_we) ? StRead : StResp;
                end
            end
            StRead: begin
                rsp_rdata_d = ext;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            funct3_q    <= '0;
            b0_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            b0_q        <= b0_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_banked_lsu.sv
// Bench for banked_lsu: a 64-bit misalign-tolerant unit and a small 32-bit strict unit,
// both checked against a flat byte-array model of memory.
module tb_banked_lsu;

    logic clk = 1'b0;
    logic rst_n;

    logic        req_valid  [2];
    logic        req_we     [2];
    logic        rsp_ready  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        rsp_valid  [2];
    logic        busy       [2];
    logic [1:0]  rsp_err    [2];
    logic [63:0] rdata0;
    logic [31:0] rdata1;

    int tests = 0;
    int fails = 0;

    // Flat byte image of each unit's window, indexed by offset from its base
    logic [7:0] mdl [2][128];

    always #5 clk = ~clk;

    banked_lsu #(
        .XLEN(64), .DEPTH(16), .BASE_ADDR(32'h0), .ALLOW_MISALIGN(1'b1)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rdata0),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    banked_lsu #(
        .XLEN(32), .DEPTH(4), .BASE_ADDR(32'h20), .ALLOW_MISALIGN(1'b0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1][31:0]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rdata1),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_rd(input int u);
        return (u == 0) ? rdata0 : {32'd0, rdata1};
    endfunction

    // Reference: apply the access rules to the byte image and produce the expected response
    task automatic model(input int u, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd,
                         output logic [63:0] rd, output logic [1:0] err);
        logic [31:0] base;
        logic [31:0] off;
        logic [63:0] last;
        logic [63:0] cap;
        int          size;
        bit          illegal, misal, fault, allow, narrow;
        base   = (u == 0) ? 32'h0 : 32'h20;
        cap    = (u == 0) ? 64'd128 : 64'd16;
        allow  = (u == 0);
        narrow = (u == 1);
        size   = 1 << f3[1:0];
        off    = addr - base;
        illegal = we ? f3[2] : (f3 == 3'b111);
        if (narrow && (size == 8 || (!we && f3 == 3'b110))) illegal = 1;
        misal = (off % size) != 0;
        last  = {32'd0, off} + 64'(size) - 64'd1;
        fault = (addr < base) || (last >= cap);
        if (illegal)              err = 2'b11;
        else if (misal && !allow) err = 2'b01;
        else if (fault)           err = 2'b10;
        else                      err = 2'b00;
        rd = '0;
        if (err == 2'b00) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[u][off + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) rd[8*i +: 8] = mdl[u][off + i];
                if (!f3[2] && rd[8*size-1]) begin
                    for (int j = 8 * size; j < 64; j++) rd[j] = 1'b1;
                end
                if (narrow) rd[63:32] = '0;
            end
        end
    endtask

    task automatic do_req(input int u, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [63:0] wd, input int hold,
                          output logic [63:0] got_rd, output logic [1:0] got_err);
        logic [63:0] exp_rd;
        logic [1:0]  exp_err;
        int          lat;
        int          exp_lat;
        check_eq("req_ready_idle", req_ready[u], 1);
        req_valid[u]  = 1'b1;
        req_we[u]     = we;
        req_funct3[u] = f3;
        req_addr[u]   = addr;
        req_wdata[u]  = wd;
        model(u, we, f3, addr, wd, exp_rd, exp_err);
        exp_lat = (we || exp_err != 2'b00) ? 1 : 2;
        @(posedge clk);
        #1;
        // Scramble request inputs: the unit must have latched what it needs
        req_valid[u]  = 1'b0;
        req_we[u]     = 1'($urandom);
        req_funct3[u] = 3'($urandom);
        req_addr[u]   = $urandom;
        req_wdata[u]  = {$urandom, $urandom};
        lat = 1;
        while (!rsp_valid[u] && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_rd  = get_rd(u);
        got_err = rsp_err[u];
        check_eq("rsp_valid", rsp_valid[u], 1);
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_rdata", got_rd, exp_rd);
        check_eq("rsp_err", got_err, exp_err);
        check_eq("busy_resp", busy[u], 1);
        check_eq("req_ready_busy", req_ready[u], 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", rsp_valid[u], 1);
            check_eq("hold_rdata", get_rd(u), exp_rd);
            check_eq("hold_ready", req_ready[u], 0);
        end
        rsp_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[u] = 1'b0;
        check_eq("rsp_valid_drop", rsp_valid[u], 0);
        check_eq("req_ready_back", req_ready[u], 1);
    endtask

    task automatic dir(input string tag, input int u, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic [1:0] exp_err);
        logic [63:0] rd;
        logic [1:0]  err;
        do_req(u, we, f3, addr, wd, 0, rd, err);
        check_eq({tag, "_rd"}, rd, exp_rd);
        check_eq({tag, "_err"}, err, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic [1:0]  err;
        logic [31:0] addr;
        int          u;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_we[i] = 0; rsp_ready[i] = 0;
            req_funct3[i] = 0; req_addr[i] = 0; req_wdata[i] = 0;
        end
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_valid", rsp_valid[i], 0);
            check_eq("rst_busy", busy[i], 0);
            check_eq("rst_err", rsp_err[i], 0);
            check_eq("rst_rdata", get_rd(i), 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rst_ready", req_ready[0], 1);

        // Fill both windows so every later load has a defined reference
        for (int r = 0; r < 16; r++)
            do_req(0, 1, 3'b011, 32'(r * 8), {$urandom, $urandom}, 0, rd, err);
        for (int r = 0; r < 4; r++)
            do_req(1, 1, 3'b010, 32'h20 + 32'(r * 4), {32'd0, $urandom}, 0, rd, err);

        // 64-bit unit, misaligned accesses split across rows
        dir("sd", 0, 1, 3'b011, 32'h21, 64'h0123456789ABCDEF, 0, 0);
        dir("ld", 0, 0, 3'b011, 32'h21, 0, 64'h0123456789ABCDEF, 0);
        dir("lwu", 0, 0, 3'b110, 32'h21, 0, 64'h0000000089ABCDEF, 0);
        dir("lw", 0, 0, 3'b010, 32'h21, 0, 64'hFFFFFFFF89ABCDEF, 0);
        dir("sh13", 0, 1, 3'b001, 32'h13, 64'h8081, 0, 0);
        dir("lh13", 0, 0, 3'b001, 32'h13, 0, 64'hFFFFFFFFFFFF8081, 0);
        dir("lhu13", 0, 0, 3'b101, 32'h13, 0, 64'h8081, 0);
        dir("lbu14", 0, 0, 3'b100, 32'h14, 0, 64'h80, 0);
        dir("sh17", 0, 1, 3'b001, 32'h17, 64'h8081, 0, 0);
        dir("lh17", 0, 0, 3'b001, 32'h17, 0, 64'hFFFFFFFFFFFF8081, 0);
        dir("lbu18", 0, 0, 3'b100, 32'h18, 0, 64'h80, 0);
        dir("ld_end", 0, 0, 3'b011, 32'h79, 0, 0, 2'b10);

        // 32-bit strict unit, window 0x20..0x2F
        dir("sw_oob", 1, 1, 3'b010, 32'h30, 64'hDEADBEEF, 0, 2'b10);
        dir("sw", 1, 1, 3'b010, 32'h2C, 64'hDEADBEEF, 0, 0);
        dir("lw32", 1, 0, 3'b010, 32'h2C, 0, 64'hDEADBEEF, 0);
        dir("lw_mis", 1, 0, 3'b010, 32'h2E, 0, 0, 2'b01);
        dir("sw_mis", 1, 1, 3'b010, 32'h2A, 64'h11111111, 0, 2'b01);
        dir("lw_keep", 1, 0, 3'b010, 32'h2C, 0, 64'hDEADBEEF, 0);
        dir("lb", 1, 0, 3'b000, 32'h2F, 0, 64'hFFFFFFDE, 0);
        dir("sb_oob", 1, 1, 3'b000, 32'h30, 64'h55, 0, 2'b10);
        dir("lw_low", 1, 0, 3'b010, 32'h10, 0, 0, 2'b10);
        dir("ld32", 1, 0, 3'b011, 32'h20, 0, 0, 2'b11);
        dir("lwu32", 1, 0, 3'b110, 32'h20, 0, 0, 2'b11);
        dir("sbu", 1, 1, 3'b100, 32'h20, 64'h1, 0, 2'b11);
        dir("l111", 1, 0, 3'b111, 32'h20, 0, 0, 2'b11);

        // Backpressure held for 5 cycles
        do_req(0, 0, 3'b011, 32'h21, 0, 5, rd, err);
        check_eq("bp_rd", rd, 64'h0123456789ABCDEF);

        // Reset with unit 0 in RESP and unit 1 in READ
        dir("sw_pre", 1, 1, 3'b010, 32'h24, 64'hCAFEF00D, 0, 0);
        req_valid[0] = 1; req_we[0] = 1; req_funct3[0] = 3'b011;
        req_addr[0] = 32'h40; req_wdata[0] = 64'h1122334455667788;
        model(0, 1, 3'b011, 32'h40, 64'h1122334455667788, rd, err);
        req_valid[1] = 1; req_we[1] = 0; req_funct3[1] = 3'b010; req_addr[1] = 32'h24;
        @(posedge clk);
        #1;
        req_valid[0] = 0;
        req_valid[1] = 0;
        check_eq("pre_rst_valid0", rsp_valid[0], 1);
        check_eq("pre_rst_busy1", busy[1], 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid0", rsp_valid[0], 0);
        check_eq("mid_rst_valid1", rsp_valid[1], 0);
        check_eq("mid_rst_busy1", busy[1], 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dir("ld_post", 0, 0, 3'b011, 32'h40, 0, 64'h1122334455667788, 0);
        dir("lw_post", 1, 0, 3'b010, 32'h24, 0, 64'hCAFEF00D, 0);

        // Randomised traffic on both units
        for (int n = 0; n < 400; n++) begin
            u = n % 2;
            if (u == 0) addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 135));
            else        addr = 32'($urandom_range(16, 52));
            do_req(u, 1'($urandom), 3'($urandom), addr, {$urandom, $urandom},
                   $urandom_range(0, 2), rd, err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
